// File: rtl/fifo_serializer.sv
// fifo_serializer: pops FIFO words and streams them LSB chunk first over valid/ready
module fifo_serializer #(
    parameter int WIDTH = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_shift_out,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int RATIO = WIDTH / OUT_WIDTH;
    localparam int IW = $clog2(RATIO);
    typedef enum logic {IDLE, SEND} state_t;
    state_t           state;
    logic [WIDTH-1:0] word;
    logic [IW-1:0]    idx;
    always_comb begin
        busy = state == SEND;
        out_valid = busy;
        out_last = busy && idx == IW'(RATIO - 1);
        out_data = busy ? word[idx*OUT_WIDTH +: OUT_WIDTH] : '0;
        // pop is gated by res so the FIFO head survives a reset untouched
        fifo_shift_out = ~res & ~fifo_empty & (~busy | (out_ready & out_last));
    end
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            word <= '0;
            idx <= '0;
        end else if (fifo_shift_out) begin
            state <= SEND;
            word <= fifo_data;
            idx <= '0;
        end else if (busy && out_ready) begin
            state <= out_last ? IDLE : SEND;
            idx <= out_last ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed checks of fifo_serializer at 16- and 32-bit chunk widths
module tb_fifo_serializer;
    logic        clk, res, ready, ready2;
    logic [63:0] mem [16];
    logic [63:0] mem2 [16];
    int          head, tail, head2, tail2, pops, pops2;
    logic        empty, empty2, shift, shift2, valid, valid2, last, last2, busy, busy2;
    logic [63:0] fdata, fdata2;
    logic [15:0] data;
    logic [31:0] data2;
    int          checks, errors;
    logic [63:0] w [3];

    assign empty = head == tail;
    assign fdata = mem[head % 16];
    assign empty2 = head2 == tail2;
    assign fdata2 = mem2[head2 % 16];

    fifo_serializer dut (
        .clk(clk), .res(res), .fifo_empty(empty), .fifo_data(fdata),
        .fifo_shift_out(shift), .out_data(data), .out_valid(valid),
        .out_last(last), .out_ready(ready), .busy(busy)
    );
    fifo_serializer #(.WIDTH(64), .OUT_WIDTH(32)) dut2 (
        .clk(clk), .res(res), .fifo_empty(empty2), .fifo_data(fdata2),
        .fifo_shift_out(shift2), .out_data(data2), .out_valid(valid2),
        .out_last(last2), .out_ready(ready2), .busy(busy2)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (shift) begin
            head <= head + 1;
            pops <= pops + 1;
        end
        if (shift2) begin
            head2 <= head2 + 1;
            pops2 <= pops2 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] v);
        mem[tail % 16] = v;
        tail++;
    endtask

    task automatic push2(input logic [63:0] v);
        mem2[tail2 % 16] = v;
        tail2++;
    endtask

    task automatic chunk(input string tag, input logic [15:0] d, input logic l);
        chk({tag, "_valid"}, 64'(valid), 64'd1);
        chk({tag, "_data"}, 64'(data), 64'(d));
        chk({tag, "_last"}, 64'(last), 64'(l));
    endtask

    initial begin
        int p0, n, k;
        logic [63:0] word;
        checks = 0; errors = 0;
        head = 0; tail = 0; head2 = 0; tail2 = 0; pops = 0; pops2 = 0;
        res = 1; ready = 0; ready2 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(valid), 0);
        chk("rst_data", 64'(data), 0);
        chk("rst_last", 64'(last), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_shift", 64'(shift), 0);
        @(negedge clk);
        res = 0;
        // empty FIFO: nothing may happen
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("empty_shift", 64'(shift), 0);
            chk("empty_valid", 64'(valid | busy), 0);
        end
        // single word
        ready = 1;
        p0 = pops;
        @(negedge clk);
        push(64'h0123_4567_89AB_CDEF);
        #1;
        chk("single_pop", 64'(shift), 1);
        chk("single_idle_valid", 64'(valid), 0);
        word = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chunk("single", word[i*16 +: 16], i == 3);
            chk("single_noshift", 64'(shift), 0);
        end
        @(negedge clk);
        #1;
        chk("single_done_valid", 64'(valid), 0);
        chk("single_pops", 64'(pops - p0), 1);
        // back-to-back three words
        w[0] = 64'h1111_2222_3333_4444;
        w[1] = 64'h5555_6666_7777_8888;
        w[2] = 64'h9999_AAAA_BBBB_CCCC;
        p0 = pops;
        @(negedge clk);
        push(w[0]); push(w[1]); push(w[2]);
        #1;
        chk("b2b_first_pop", 64'(shift), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            word = w[i / 4];
            chunk("b2b", word[(i % 4)*16 +: 16], i % 4 == 3);
            chk("b2b_shift", 64'(shift), 64'(i % 4 == 3 && i < 11));
        end
        @(negedge clk);
        #1;
        chk("b2b_done_valid", 64'(valid), 0);
        chk("b2b_pops", 64'(pops - p0), 3);
        // backpressure during chunk index 2, with a second word waiting
        word = 64'h0123_4567_89AB_CDEF;
        p0 = pops;
        @(negedge clk);
        push(word);
        #1;
        @(negedge clk);
        #1;
        chunk("bp0", 16'hCDEF, 0);
        @(negedge clk);
        #1;
        chunk("bp1", 16'h89AB, 0);
        @(negedge clk);
        ready = 0;
        push(64'hDEAD_BEEF_CAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            #1;
            chunk("bp_hold", 16'h4567, 0);
            chk("bp_noshift", 64'(shift), 0);
            @(negedge clk);
        end
        ready = 1;
        #1;
        chunk("bp_hold_end", 16'h4567, 0);
        @(negedge clk);
        #1;
        chunk("bp3", 16'h0123, 1);
        chk("bp3_shift", 64'(shift), 1);
        word = 64'hDEAD_BEEF_CAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chunk("bp_next", word[i*16 +: 16], i == 3);
        end
        @(negedge clk);
        #1;
        chk("bp_pops", 64'(pops - p0), 2);
        chk("bp_idle", 64'(valid), 0);
        // reset mid-word
        @(negedge clk);
        push(64'h1234_5678_9ABC_DEF0);
        #1;
        @(negedge clk);
        #1;
        chunk("mid0", 16'hDEF0, 0);
        @(negedge clk);
        #1;
        chunk("mid1", 16'h9ABC, 0);
        @(negedge clk);
        push(64'hFFFF_0000_AAAA_5555);
        res = 1;
        #1;
        chk("mid_rst_valid", 64'(valid), 0);
        chk("mid_rst_data", 64'(data), 0);
        chk("mid_rst_last", 64'(last), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_shift", 64'(shift), 0);
        @(negedge clk);
        res = 0;
        #1;
        chk("mid_pop", 64'(shift), 1);
        word = 64'hFFFF_0000_AAAA_5555;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chunk("mid_new", word[i*16 +: 16], i == 3);
        end
        @(negedge clk);
        #1;
        chk("mid_idle", 64'(valid), 0);
        // 32-bit chunks, random backpressure, lossless stream
        w[0] = 64'hA5A5_A5A5_0F0F_0F0F;
        w[1] = 64'h0000_0001_FFFF_FFFE;
        w[2] = 64'h8765_4321_1357_9BDF;
        @(negedge clk);
        push2(w[0]); push2(w[1]); push2(w[2]);
        n = 0;
        k = 0;
        while (n < 6 && k < 300) begin
            @(negedge clk);
            #1;
            ready2 = 1'($urandom);
            #1;
            if (valid2 && ready2) begin
                word = w[n / 2];
                chk("w32_data", 64'(data2), 64'(word[(n % 2)*32 +: 32]));
                chk("w32_last", 64'(last2), 64'(n % 2));
                n++;
            end
            k++;
        end
        chk("w32_count", 64'(n), 6);
        ready2 = 1;
        @(negedge clk);
        #1;
        chk("w32_idle", 64'(valid2), 0);
        chk("w32_pops", 64'(pops2), 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
